pwm_fade_seq: RTL

//   Upstream command sequencer for the PWM_in register-write port (d/sel).

---
 rtl/pwm_fade_seq.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/pwm_fade_seq.sv
// Command sequencer for the PWM_in register port: writes top, clears the counter,
// then keeps rewriting the compare register to fade duty 0 -> top -> 0 and back.
module pwm_fade_seq #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         stop,
  input  logic [W-1:0] top_val,
  input  logic [W-1:0] step,
  input  logic [W-1:0] hold,
  output logic [W-1:0] d,
  output logic [1:0]   sel,
  output logic         busy,
  output logic         dir,
  output logic [W-1:0] level,
  output logic [2:0]   state_dbg
);

  typedef enum logic [2:0] {IDLE, W_TOP, W_CNT, W_CMP, WAIT} state_t;

  // Write selects presented to PWM_in.
  localparam logic [1:0] SEL_NONE = 2'd0;
  localparam logic [1:0] SEL_CMP  = 2'd1;
  localparam logic [1:0] SEL_TOP  = 2'd2;
  localparam logic [1:0] SEL_CNT  = 2'd3;

  state_t       state, state_n;
  logic [W-1:0] top_r, top_n;
  logic [W-1:0] step_r, step_n;
  logic [W-1:0] hold_r, hold_n;
  logic [W-1:0] timer, timer_n;
  logic [W-1:0] d_n, level_n;
  logic [1:0]   sel_n;
  logic         dir_n, busy_n;

  logic [W:0]   sum;
  logic [W-1:0] fade_level;
  logic         fade_dir;

  // Next compare value; the extra bit keeps level+step from wrapping past top.
  always_comb begin
    sum        = {1'b0, level} + {1'b0, step_r};
    fade_level = level;
    fade_dir   = dir;
    if (!dir) begin
      if (sum >= {1'b0, top_r}) begin
        fade_level = top_r;
        fade_dir   = 1'b1;
      end else begin
        fade_level = sum[W-1:0];
      end
    end else begin
      if (level <= step_r) begin
        fade_level = '0;
        fade_dir   = 1'b0;
      end else begin
        fade_level = level - step_r;
      end
    end
  end

  always_comb begin
    state_n = state;
    top_n   = top_r;
    step_n  = step_r;
    hold_n  = hold_r;
    timer_n = timer;
    d_n     = d;
    sel_n   = SEL_NONE;
    level_n = level;
    dir_n   = dir;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          top_n   = top_val;
          step_n  = step;
          hold_n  = hold;
          sel_n   = SEL_TOP;
          d_n     = top_val;
          state_n = W_TOP;
        end
      end
      W_TOP: begin
        sel_n   = SEL_CNT;
        d_n     = '0;
        state_n = W_CNT;
      end
      W_CNT: begin
        sel_n   = SEL_CMP;
        d_n     = '0;
        level_n = '0;
        dir_n   = 1'b0;
        timer_n = hold_r;
        state_n = W_CMP;
      end
      W_CMP, WAIT: begin
        state_n = WAIT;
        if (timer != '0) begin
          timer_n = timer - W'(1);
        end else begin
          sel_n   = SEL_CMP;
          d_n     = fade_level;
          level_n = fade_level;
          dir_n   = fade_dir;
          timer_n = hold_r;
        end
      end
      default: state_n = IDLE;
    endcase
    // Abort overrides any pending update: park the compare at 0.
    if (stop && state != IDLE) begin
      sel_n   = SEL_CMP;
      d_n     = '0;
      level_n = '0;
      dir_n   = 1'b0;
      timer_n = '0;
      state_n = IDLE;
    end
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      top_r  <= '0;
      step_r <= '0;
      hold_r <= '0;
      timer  <= '0;
      d      <= '0;
      sel    <= SEL_NONE;
      busy   <= 1'b0;
      dir    <= 1'b0;
      level  <= '0;
    end else begin
      state  <= state_n;
      top_r  <= top_n;
      step_r <= step_n;
      hold_r <= hold_n;
      timer  <= timer_n;
      d      <= d_n;
      sel    <= sel_n;
      busy   <= busy_n;
      dir    <= dir_n;
      level  <= level_n;
    end
  end

  assign state_dbg = state;

endmodule
